// File: rtl/seg_pattern_decoder.sv
// ---------------------------------------------------------------------------
// seg_pattern_decoder
//
// Purpose:
//   Snoops a multiplexed, active-low 7-segment bus and recovers the 5-bit
//   display code shown on each digit. Every digit is debounced on its own
//   strobes. The accepted codes are kept in a per-digit table, and a
//   valid/ready change event is raised whenever a digit's accepted value
//   changes. This is the inverse of the hex-to-segment driver, so readback
//   logic can confirm what the status display is really showing.
//
// Parameters:
//   NUM_DIGITS  number of multiplexed digits (1..8)
//   STABLE_CNT  consecutive identical strobed samples needed to accept (1..15)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   seg_in     active-low segment bus, bit7 = DP, bits6..0 = g..a
//   dig_sel    one-hot active-high digit strobe, all-zero = bus idle
//   codes_out  accepted code per digit, digit i at [5i+4:5i]
//   err_out    per digit, accepted pattern was not a known glyph
//   ev_valid   change event pending
//   ev_ready   consumer accepts the event
//   ev_digit   digit index of the pending event
//   ev_code    code of the pending event
//   ev_err     err flag of the pending event
//   overrun    sticky, an event was dropped because the slot was busy
//   clr_ovr    clears overrun
//   dp_out     (SEG_DP_SPLIT_EN only) debounced decimal-point state per digit
//
// Optional feature macro: SEG_DP_SPLIT_EN
//   When defined, DP is ignored for the glyph lookup and tracked separately
//   on dp_out. The lone-DP pattern 7F still decodes as its own glyph.
// ---------------------------------------------------------------------------
module seg_pattern_decoder #(
  parameter int NUM_DIGITS = 6,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [5*NUM_DIGITS-1:0] codes_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [2:0]              ev_digit,
  output logic [4:0]              ev_code,
  output logic                    ev_err,
  output logic                    overrun,
`ifdef SEG_DP_SPLIT_EN
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  input  logic                    clr_ovr
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  // Glyph table lookup, returns {err, code}. Both "D" and "d" share A1, so
  // code 17 never appears.
  function automatic logic [5:0] lookup(input logic [7:0] p);
    logic [5:0] r;
    case (p)
      8'hC0:   r = {1'b0, 5'd0};
      8'hF9:   r = {1'b0, 5'd1};
      8'hA4:   r = {1'b0, 5'd2};
      8'hB0:   r = {1'b0, 5'd3};
      8'h99:   r = {1'b0, 5'd4};
      8'h92:   r = {1'b0, 5'd5};
      8'h82:   r = {1'b0, 5'd6};
      8'hF8:   r = {1'b0, 5'd7};
      8'h80:   r = {1'b0, 5'd8};
      8'h90:   r = {1'b0, 5'd9};
      8'h88:   r = {1'b0, 5'd10};
      8'h83:   r = {1'b0, 5'd11};
      8'hC6:   r = {1'b0, 5'd12};
      8'hA1:   r = {1'b0, 5'd13};
      8'h86:   r = {1'b0, 5'd14};
      8'h8E:   r = {1'b0, 5'd15};
      8'hAF:   r = {1'b0, 5'd16};
      8'h87:   r = {1'b0, 5'd18};
      8'hF7:   r = {1'b0, 5'd19};
      8'hBF:   r = {1'b0, 5'd20};
      8'hAB:   r = {1'b0, 5'd21};
      8'h7F:   r = {1'b0, 5'd22};
      8'hC7:   r = {1'b0, 5'd23};
      8'hC1:   r = {1'b0, 5'd24};
      8'hFF:   r = {1'b0, 5'd31};
      default: r = {1'b1, 5'd31};
    endcase
    return r;
  endfunction

  // Per-digit state. The candidate holds the decoded key {dp, 1, err, code},
  // so that two different illegal patterns still count as "the same" sample.
  logic [7:0] r_cand [NUM_DIGITS];
  logic [3:0] r_cnt  [NUM_DIGITS];
  // Accepted value {dp, err, code}. The dp bit stays 0 when DP is not split.
  logic [6:0] r_acc  [NUM_DIGITS];

  logic [5:0] w_look;
  logic       w_dp;
  logic [7:0] w_key;
  logic [6:0] w_newAcc;

  // Combinational decode of the bus. With DP splitting, the DP bit is taken
  // out of the glyph and carried as its own debounced bit. The lone-DP glyph
  // 7F keeps its own code and is not treated as a lit DP.
  always_comb begin
`ifdef SEG_DP_SPLIT_EN
    if (seg_in == 8'h7F) begin
      w_look = {1'b0, 5'd22};
      w_dp   = 1'b0;
    end else begin
      w_look = lookup(seg_in | 8'h80);
      w_dp   = ~seg_in[7];
    end
`else
    w_look = lookup(seg_in);
    w_dp   = 1'b0;
`endif
    w_key    = {w_dp, 1'b1, w_look};
    w_newAcc = {w_dp, w_look};
  end

  logic [3:0] w_selCount;
  logic       w_oneHot;
  logic [2:0] w_idx;
  logic [7:0] w_selCand;
  logic [3:0] w_selCnt;
  logic [6:0] w_selAcc;
  logic [3:0] w_nextCnt;
  logic       w_accept;

  // Find the strobed digit and pull out its state. Strobes with zero or
  // several bits set are ignored. Because the strobe is one-hot, at most one
  // digit can produce an event in any cycle, so a single event path is enough.
  always_comb begin
    w_selCount = 4'd0;
    w_idx      = 3'd0;
    w_selCand  = 8'hFF;
    w_selCnt   = 4'd0;
    w_selAcc   = {2'b00, 5'd31};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_selCount = w_selCount + {3'b000, dig_sel[i]};
      if (dig_sel[i]) begin
        w_idx     = 3'(i);
        w_selCand = r_cand[i];
        w_selCnt  = r_cnt[i];
        w_selAcc  = r_acc[i];
      end
    end
    w_oneHot = (w_selCount == 4'd1);

    // The counter saturates at STABLE, so a steady glyph keeps its accepted
    // state without retriggering an event.
    if (w_key == w_selCand)
      w_nextCnt = (w_selCnt >= STABLE) ? STABLE : (w_selCnt + 4'd1);
    else
      w_nextCnt = 4'd1;

    w_accept = w_oneHot && (w_nextCnt == STABLE) && (w_newAcc != w_selAcc);
  end

  // Debounce and accepted-value table. Only the strobed digit moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_cand[i] <= 8'hFF;
        r_cnt[i]  <= 4'd0;
        r_acc[i]  <= {2'b00, 5'd31};
      end
    end else if (w_oneHot) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_sel[i]) begin
          r_cand[i] <= w_key;
          r_cnt[i]  <= w_nextCnt;
          if (w_accept)
            r_acc[i] <= w_newAcc;
        end
      end
    end
  end

  // One-entry event slot. A new event may replace the pending one only in
  // the cycle where the consumer takes it. Otherwise the new event is lost
  // and overrun records the loss. A drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_digit <= 3'd0;
      ev_code  <= 5'd0;
      ev_err   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!ev_valid || ev_ready) begin
          ev_valid <= 1'b1;
          ev_digit <= w_idx;
          ev_code  <= w_newAcc[4:0];
          ev_err   <= w_newAcc[5];
        end else begin
          overrun <= 1'b1;
        end
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end

      if (!(w_accept && ev_valid && !ev_ready) && clr_ovr)
        overrun <= 1'b0;
    end
  end

  // Flatten the accepted table onto the output buses.
  always_comb begin
    codes_out = '0;
    err_out   = '0;
`ifdef SEG_DP_SPLIT_EN
    dp_out    = '0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      codes_out[5*i +: 5] = r_acc[i][4:0];
      err_out[i]          = r_acc[i][5];
`ifdef SEG_DP_SPLIT_EN
      dp_out[i]           = r_acc[i][6];
`endif
    end
  end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Testbench for seg_pattern_decoder: directed scenarios followed by random
// bus traffic, all compared every cycle against a behavioural model.
module tb_seg_pattern_decoder;

  localparam int ND = 6;
  localparam int SC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      seg_in;
  logic [ND-1:0]   dig_sel;
  logic [5*ND-1:0] codes_out;
  logic [ND-1:0]   err_out;
  logic            ev_valid;
  logic            ev_ready;
  logic [2:0]      ev_digit;
  logic [4:0]      ev_code;
  logic            ev_err;
  logic            overrun;
  logic            clr_ovr;
`ifdef SEG_DP_SPLIT_EN
  logic [ND-1:0]   dp_out;
`endif

  int checkCount = 0;
  int passCount  = 0;

  seg_pattern_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .codes_out (codes_out),
    .err_out   (err_out),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_digit  (ev_digit),
    .ev_code   (ev_code),
    .ev_err    (ev_err),
    .overrun   (overrun),
`ifdef SEG_DP_SPLIT_EN
    .dp_out    (dp_out),
`endif
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  // Glyph table as plain lists
  logic [7:0] pats [25] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82,
                            8'hF8, 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1,
                            8'h86, 8'h8E, 8'hAF, 8'h87, 8'hF7, 8'hBF, 8'hAB,
                            8'h7F, 8'hC7, 8'hC1, 8'hFF};
  int         cds  [25] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14,
                            15, 16, 18, 19, 20, 21, 22, 23, 24, 31};

  // Model state. Keys are dp*64 + err*32 + code.
  int mCand [ND];
  int mCnt  [ND];
  int mAcc  [ND];
  bit mEvValid;
  int mEvDigit, mEvCode, mEvErr;
  bit mOvr;

  // Reference meaning of a bus pattern, as a key
  function automatic int refKey(input logic [7:0] s);
    logic [7:0] p;
    int dp;
    p  = s;
    dp = 0;
`ifdef SEG_DP_SPLIT_EN
    if (s == 8'h7F) return 22;
    dp = s[7] ? 0 : 1;
    p  = s | 8'h80;
`endif
    for (int i = 0; i < 25; i++)
      if (pats[i] == p) return dp * 64 + cds[i];
    return dp * 64 + 32 + 31;
  endfunction

  // Advance the model by one clock edge
  task automatic modelStep(input logic [7:0] s, input logic [ND-1:0] sel,
                           input bit rdy, input bit clr, input bit rs);
    bit gen;
    bit drop;
    int idx;
    int key;
    if (rs) begin
      for (int i = 0; i < ND; i++) begin
        mCand[i] = -1;
        mCnt[i]  = 0;
        mAcc[i]  = 31;
      end
      mEvValid = 0; mEvDigit = 0; mEvCode = 0; mEvErr = 0; mOvr = 0;
      return;
    end
    gen  = 0;
    drop = 0;
    idx  = 0;
    key  = 0;
    if ($countones(sel) == 1) begin
      for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
      key = refKey(s);
      if (key == mCand[idx]) begin
        mCnt[idx] = (mCnt[idx] + 1 > SC) ? SC : mCnt[idx] + 1;
      end else begin
        mCand[idx] = key;
        mCnt[idx]  = 1;
      end
      if (mCnt[idx] == SC && key != mAcc[idx]) begin
        mAcc[idx] = key;
        gen = 1;
      end
    end
    if (gen) begin
      if (!mEvValid || rdy) begin
        mEvValid = 1;
        mEvDigit = idx;
        mEvCode  = key % 32;
        mEvErr   = (key / 32) % 2;
      end else begin
        drop = 1;
      end
    end else if (mEvValid && rdy) begin
      mEvValid = 0;
    end
    if (drop) mOvr = 1;
    else if (clr) mOvr = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%h expected=%h (t=%0t)",
                  tag, observed, expected, $time);
  endtask

  task automatic compareAll();
    logic [5*ND-1:0] expCodes;
    logic [ND-1:0]   expErr;
    for (int i = 0; i < ND; i++) begin
      expCodes[5*i +: 5] = 5'(mAcc[i] % 32);
      expErr[i]          = ((mAcc[i] / 32) % 2) == 1;
    end
    checkOutput("codes", 32'(codes_out), 32'(expCodes));
    checkOutput("err", 32'(err_out), 32'(expErr));
    checkOutput("event", 32'({ev_valid, ev_digit, ev_code, ev_err}),
                32'({mEvValid, 3'(mEvDigit), 5'(mEvCode), 1'(mEvErr)}));
    checkOutput("overrun", 32'(overrun), 32'(mOvr));
`ifdef SEG_DP_SPLIT_EN
    begin
      logic [ND-1:0] expDp;
      for (int i = 0; i < ND; i++) expDp[i] = (mAcc[i] / 64) == 1;
      checkOutput("dp", 32'(dp_out), 32'(expDp));
    end
`endif
  endtask

  // Drive one cycle of inputs, update the model on the edge, then compare
  task automatic applyStimulus(input logic [7:0] s, input logic [ND-1:0] sel,
                               input bit rdy, input bit clr, input bit rs);
    @(negedge clk);
    seg_in   = s;
    dig_sel  = sel;
    ev_ready = rdy;
    clr_ovr  = clr;
    rst      = rs;
    @(posedge clk);
    modelStep(s, sel, rdy, clr, rs);
    #1;
    compareAll();
  endtask

  logic [7:0] curPat [ND];

  initial begin
    seg_in = 8'hFF; dig_sel = '0; ev_ready = 1'b1; clr_ovr = 1'b0; rst = 1'b1;

    // Reset
    applyStimulus(8'hFF, 6'b0, 1, 0, 1);
    applyStimulus(8'hFF, 6'b0, 1, 0, 1);
    checkOutput("rstCodes", 32'(codes_out), 32'h3FFF_FFFF);
    checkOutput("rstEvent", 32'({ev_valid, ev_digit, ev_code, ev_err, overrun, err_out}), 32'd0);

    // Digit 0 shows 4
    for (int k = 0; k < SC; k++) applyStimulus(8'h99, 6'b000001, 1, 0, 0);
    checkOutput("t1Code", 32'(codes_out[4:0]), 32'd4);
    checkOutput("t1Ev", 32'({ev_valid, ev_digit, ev_code, ev_err}), 32'({1'b1, 3'd0, 5'd4, 1'b0}));
    applyStimulus(8'h99, 6'b000000, 1, 0, 0);
    checkOutput("t1EvDone", 32'(ev_valid), 32'd0);

    // Digit 2: A4 A4 B0 B0 B0
    applyStimulus(8'hA4, 6'b000100, 1, 0, 0);
    applyStimulus(8'hA4, 6'b000100, 1, 0, 0);
    checkOutput("t2NoEv", 32'(ev_valid), 32'd0);
    for (int k = 0; k < 3; k++) applyStimulus(8'hB0, 6'b000100, 1, 0, 0);
    checkOutput("t2Ev", 32'({ev_valid, ev_digit, ev_code}), 32'({1'b1, 3'd2, 5'd3}));

    // Digit 1: illegal pattern, then blank
    for (int k = 0; k < 3; k++) applyStimulus(8'h55, 6'b000010, 1, 0, 0);
    checkOutput("t3Err", 32'({err_out[1], codes_out[9:5], ev_err}), 32'({1'b1, 5'd31, 1'b1}));
    for (int k = 0; k < 3; k++) applyStimulus(8'hFF, 6'b000010, 1, 0, 0);
    checkOutput("t3Blank", 32'({err_out[1], ev_valid, ev_code, ev_err}), 32'({1'b0, 1'b1, 5'd31, 1'b0}));
    applyStimulus(8'hFF, 6'b000000, 1, 0, 0);

    // Stalled consumer: second event is dropped
    for (int k = 0; k < 3; k++) applyStimulus(8'hC0, 6'b000001, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(8'hF9, 6'b000010, 0, 0, 0);
    checkOutput("t4Held", 32'({ev_valid, ev_digit, ev_code, overrun}), 32'({1'b1, 3'd0, 5'd0, 1'b1}));
    checkOutput("t4Codes", 32'(codes_out[9:0]), 32'({5'd1, 5'd0}));
    applyStimulus(8'hFF, 6'b000000, 1, 1, 0);
    checkOutput("t4Clr", 32'({overrun, ev_valid}), 32'd0);

    // Idle and multi-hot strobes are ignored
    for (int k = 0; k < 10; k++)
      applyStimulus(8'($urandom), (k % 2 == 0) ? 6'b000011 : 6'b000000, 1, 0, 0);

    // Reset during a partial debounce
    applyStimulus(8'h92, 6'b010000, 1, 0, 0);
    applyStimulus(8'h92, 6'b010000, 1, 0, 1);
    checkOutput("t5Rst", 32'(codes_out), 32'h3FFF_FFFF);
    applyStimulus(8'h92, 6'b010000, 1, 0, 0);
    applyStimulus(8'h92, 6'b010000, 1, 0, 0);
    checkOutput("t5NoEv", 32'({ev_valid, codes_out[24:20]}), 32'({1'b0, 5'd31}));

    // Digit 3 with DP lit on a 4
    for (int k = 0; k < 3; k++) applyStimulus(8'h19, 6'b001000, 1, 0, 0);
`ifdef SEG_DP_SPLIT_EN
    checkOutput("t6Dp", 32'({codes_out[19:15], dp_out[3], err_out[3]}), 32'({5'd4, 1'b1, 1'b0}));
`else
    checkOutput("t6NoDp", 32'({codes_out[19:15], err_out[3]}), 32'({5'd31, 1'b1}));
`endif

    // Random traffic: each digit holds a glyph that changes now and then
    for (int i = 0; i < ND; i++) curPat[i] = pats[$urandom_range(24)];
    for (int n = 0; n < 1500; n++) begin
      logic [ND-1:0] sel;
      int r;
      int d;
      if ($urandom_range(7) == 0) begin
        d = $urandom_range(ND - 1);
        curPat[d] = ($urandom_range(19) == 0) ? 8'($urandom) : pats[$urandom_range(24)];
      end
      r = $urandom_range(9);
      d = $urandom_range(ND - 1);
      if (r == 0) sel = '0;
      else if (r == 1) sel = ND'((1 << d) | (1 << $urandom_range(ND - 1)));
      else sel = ND'(1 << d);
      applyStimulus(curPat[d], sel, $urandom_range(3) != 0,
                    $urandom_range(15) == 0, $urandom_range(499) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
